// File: rtl/wt_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wt_mac_pipe                                                   |
// | Purpose  : Pipelined WIDTH x WIDTH Wallace-tree multiplier with a        |
// |            valid/ready handshake, full backpressure and an optional      |
// |            multiply-accumulate mode into a 2*WIDTH accumulator.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wt_mac_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           alufn,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic [2*WIDTH-1:0]   acc_out
);

  localparam int c_PW  = 2 * WIDTH;
  localparam int c_MID = STAGES - 2;

  // Row count after one level of 3:2 compression.
  function automatic int rows_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Row count entering a given reduction level.
  function automatic int rows_at(input int lvl);
    int n;
    n = c_PW;
    for (int i = 0; i < lvl; i++) n = rows_next(n);
    return n;
  endfunction

  // Number of levels needed to reach two rows.
  function automatic int tree_levels();
    int n;
    int k;
    n = c_PW;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (n > 2) begin
        n = rows_next(n);
        k++;
      end
    end
    return k;
  endfunction

  localparam int c_LEVELS = tree_levels();

  logic              w_advance;
  logic [c_PW-1:0]   w_a_ext;
  logic [c_PW-1:0]   w_b_ext;
  logic              r_s1_vld;
  logic              r_s1_acc;
  logic [c_PW-1:0]   r_s1_a;
  logic [c_PW-1:0]   r_s1_b;
  logic [c_PW-1:0]   w_red_s;
  logic [c_PW-1:0]   w_red_c;
  logic              w_tail_vld;
  logic              w_tail_acc;
  logic [c_PW-1:0]   w_tail_s;
  logic [c_PW-1:0]   w_tail_c;
  logic [c_PW-1:0]   w_prod;
  logic [c_PW-1:0]   w_acc_base;
  logic [c_PW-1:0]   w_result;
  logic              r_out_valid;
  logic [c_PW-1:0]   r_out_data;
  logic [c_PW-1:0]   r_acc;

  // The whole pipe moves together unless a result is waiting on the consumer.
  assign w_advance = !(r_out_valid && !out_ready);
  assign in_ready  = w_advance;

  // Extending to 2*WIDTH up front lets one unsigned tree serve both modes:
  // the low 2*WIDTH bits of the extended product are exact either way.
  assign w_a_ext = {{WIDTH{alufn[0] & a[WIDTH-1]}}, a};
  assign w_b_ext = {{WIDTH{alufn[0] & b[WIDTH-1]}}, b};

  // Input stage: capture the extended operands and the accumulate flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_acc <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
    end else if (w_advance) begin
      r_s1_vld <= in_valid;
      r_s1_acc <= alufn[1];
      r_s1_a   <= w_a_ext;
      r_s1_b   <= w_b_ext;
    end
  end

  // Wallace reduction: each level compresses groups of three rows into a
  // sum row and a shifted carry row; leftover rows pass straight through.
  for (genvar l = 0; l < c_LEVELS; l++) begin : g_lvl
    localparam int c_NI = rows_at(l);
    localparam int c_NO = rows_at(l + 1);
    localparam int c_NG = c_NI / 3;
    logic [c_PW-1:0] src [c_NI];
    logic [c_PW-1:0] dst [c_NO];

    if (l == 0) begin : g_pp
      for (genvar i = 0; i < c_NI; i++) begin : g_row
        assign src[i] = r_s1_b[i] ? (r_s1_a << i) : '0;
      end
    end else begin : g_chain
      for (genvar i = 0; i < c_NI; i++) begin : g_row
        assign src[i] = g_lvl[l-1].dst[i];
      end
    end

    for (genvar g = 0; g < c_NG; g++) begin : g_csa
      assign dst[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
      assign dst[2*g+1] = ((src[3*g] & src[3*g+1]) | (src[3*g] & src[3*g+2]) |
                           (src[3*g+1] & src[3*g+2])) << 1;
    end

    for (genvar k = 0; k < c_NI - 3*c_NG; k++) begin : g_pass
      assign dst[2*c_NG+k] = src[3*c_NG+k];
    end
  end

  assign w_red_s = g_lvl[c_LEVELS-1].dst[0];
  assign w_red_c = g_lvl[c_LEVELS-1].dst[1];

  if (c_MID == 0) begin : g_no_mid
    assign w_tail_vld = r_s1_vld;
    assign w_tail_acc = r_s1_acc;
    assign w_tail_s   = w_red_s;
    assign w_tail_c   = w_red_c;
  end else begin : g_mid
    logic [c_MID-1:0] r_vld;
    logic [c_MID-1:0] r_acc_f;
    logic [c_PW-1:0]  r_s [c_MID];
    logic [c_PW-1:0]  r_c [c_MID];

    // Carry-save pipeline: hold the two reduced rows until the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld   <= '0;
        r_acc_f <= '0;
        for (int i = 0; i < c_MID; i++) begin
          r_s[i] <= '0;
          r_c[i] <= '0;
        end
      end else if (w_advance) begin
        r_vld[0]   <= r_s1_vld;
        r_acc_f[0] <= r_s1_acc;
        r_s[0]     <= w_red_s;
        r_c[0]     <= w_red_c;
        for (int i = 1; i < c_MID; i++) begin
          r_vld[i]   <= r_vld[i-1];
          r_acc_f[i] <= r_acc_f[i-1];
          r_s[i]     <= r_s[i-1];
          r_c[i]     <= r_c[i-1];
        end
      end
    end

    assign w_tail_vld = r_vld[c_MID-1];
    assign w_tail_acc = r_acc_f[c_MID-1];
    assign w_tail_s   = r_s[c_MID-1];
    assign w_tail_c   = r_c[c_MID-1];
  end

  // Final carry-propagate add, then optional accumulate. A clear arriving
  // with an accumulate beat makes that beat start from zero.
  assign w_prod     = w_tail_s + w_tail_c;
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_result   = w_tail_acc ? (w_acc_base + w_prod) : w_prod;

  // Output register: load a new result only when a valid beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_out_valid <= w_tail_vld;
      if (w_tail_vld) r_out_data <= w_result;
    end
  end

  // Accumulator: updated by accumulate beats, cleared by acc_clr even in a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_advance && w_tail_vld && w_tail_acc) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign acc_out   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_wt_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wt_mac_pipe                                                |
// | Purpose  : Self-checking bench for wt_mac_pipe (WIDTH=16, STAGES=3).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wt_mac_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  alufn;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] acc_out;

  int n_cmp = 0;
  int n_err = 0;

  wt_mac_pipe #(.WIDTH(16), .STAGES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alufn     (alufn),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: exact arithmetic on 64-bit integers, low 32 bits kept.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                           input logic sgn);
    longint px;
    if (sgn) px = longint'($signed(x)) * longint'($signed(y));
    else     px = longint'({48'd0, x}) * longint'({48'd0, y});
    return px[31:0];
  endfunction

  // Send one beat on an idle pipe and wait for its result.
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tbv, input logic [1:0] tf,
                          output logic [31:0] d, output logic [31:0] ac, output bit ok);
    ok = 1'b0;
    d  = '0;
    ac = '0;
    out_ready = 1'b1;
    a = ta; b = tbv; alufn = tf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        d  = out_data;
        ac = acc_out;
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_cmp++; if (acc_out !== 32'h0) begin n_err++; $display("FAIL rst_acc_out: got %h expected 0", acc_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1; alufn = 2'b00;
    a = 16'd36; b = 16'd36; in_valid = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early1: got %b expected 0", out_valid); end
    a = 16'd0; b = 16'd36;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early2: got %b expected 0", out_valid); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000510) begin n_err++; $display("FAIL lat_beat0: got v=%b d=%h expected v=1 d=00000510", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000000) begin n_err++; $display("FAIL lat_beat1: got v=%b d=%h expected v=1 d=00000000", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed();
    logic [15:0] ta [4] = '{16'hFFDC, 16'hFFDC, 16'h0024, 16'hFFDC};
    logic [15:0] tv [4] = '{16'h0024, 16'hFFDC, 16'hFFDC, 16'h0024};
    logic [1:0]  tf [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    logic [31:0] te [4] = '{32'hFFFFFAF0, 32'h00000510, 32'hFFFFFAF0, 32'h0023FAF0};
    logic [31:0] d, ac;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      run_beat(ta[i], tv[i], tf[i], d, ac, ok);
      n_cmp++; if (!ok || d !== te[i]) begin n_err++; $display("FAIL signed_%0d: got %h (ok=%0d) expected %h", i, d, ok, te[i]); end
    end
  endtask

  task automatic test_mac();
    logic [15:0] ta [3] = '{16'd2, 16'd4, 16'd6};
    logic [15:0] tv [3] = '{16'd3, 16'd5, 16'd7};
    logic [31:0] te [3] = '{32'd6, 32'd26, 32'd68};
    logic [31:0] d, ac;
    bit ok;
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL mac_clr: got %h expected 0", acc_out); end
    for (int i = 0; i < 3; i++) begin
      run_beat(ta[i], tv[i], 2'b10, d, ac, ok);
      n_cmp++; if (!ok || d !== te[i] || ac !== te[i]) begin n_err++; $display("FAIL mac_%0d: got d=%h acc=%h expected %h", i, d, ac, te[i]); end
    end
    run_beat(16'd1, 16'd1, 2'b00, d, ac, ok);
    n_cmp++; if (!ok || d !== 32'd1 || acc_out !== 32'd68) begin n_err++; $display("FAIL mac_plain: got d=%h acc=%h expected d=1 acc=68", d, acc_out); end
  endtask

  task automatic test_wrap_collision();
    logic [31:0] d, ac;
    bit ok;
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    run_beat(16'hFFFF, 16'h0001, 2'b11, d, ac, ok);
    n_cmp++; if (!ok || d !== 32'hFFFFFFFF || ac !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_fill: got d=%h acc=%h expected ffffffff", d, ac); end
    run_beat(16'd1, 16'd1, 2'b10, d, ac, ok);
    n_cmp++; if (!ok || d !== 32'h0 || ac !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got d=%h acc=%h expected 0", d, ac); end
    run_beat(16'd2, 16'd2, 2'b10, d, ac, ok);
    n_cmp++; if (!ok || ac !== 32'd4) begin n_err++; $display("FAIL coll_pre: got acc=%h expected 4", ac); end
    // Beat (3,3) reaches the output register on the third edge after it is offered.
    out_ready = 1'b1;
    a = 16'd3; b = 16'd3; alufn = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd9 || acc_out !== 32'd9) begin n_err++; $display("FAIL coll: got v=%b d=%h acc=%h expected v=1 d=9 acc=9", out_valid, out_data, acc_out); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] pa [5];
    logic [15:0] pb [5];
    logic [31:0] pe [5];
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 5; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
      pe[i] = ref_prod(pa[i], pb[i], 1'b0);
    end
    alufn = 2'b00;
    for (int k = 0; k < 60 && got < 5; k++) begin
      in_valid = (sent < 5);
      if (sent < 5) begin a = pa[sent]; b = pb[sent]; end
      out_ready = (k >= 10);
      acc_clr = (k == 6);
      #1;
      if (k >= 3 && k <= 9) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== pe[0]) begin n_err++; $display("FAIL bp_hold k=%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, pe[0]); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready k=%0d: got %b expected 0", k, in_ready); end
      end
      if (k == 7) begin
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL bp_stall_clr: got %h expected 0", acc_out); end
      end
      if (k == 9) begin
        n_cmp++; if (sent !== 3) begin n_err++; $display("FAIL bp_accepted: got %0d expected 3", sent); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== pe[got]) begin n_err++; $display("FAIL bp_drain_%0d: got %h expected %h", got, out_data, pe[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL bp_count: got %0d results expected 5", got); end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d, ac;
    bit ok;
    int stale = 0;
    run_beat(16'd3, 16'd3, 2'b10, d, ac, ok);
    n_cmp++; if (!ok || ac !== 32'd9) begin n_err++; $display("FAIL rm_pre: got acc=%h expected 9", ac); end
    out_ready = 1'b1; alufn = 2'b00;
    a = 16'd7; b = 16'd8; in_valid = 1'b1;
    tick();
    a = 16'd9; b = 16'd9;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || acc_out !== 32'h0) begin n_err++; $display("FAIL rm_async: got v=%b d=%h acc=%h expected all 0", out_valid, out_data, acc_out); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rm_stale: got %0d stale results expected 0", stale); end
    a = 16'd5; b = 16'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_early: got %b expected 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd25) begin n_err++; $display("FAIL rm_new: got v=%b d=%h expected v=1 d=19", out_valid, out_data); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q_d [$];
    logic [31:0] q_a [$];
    logic [31:0] macc = 32'd0;
    logic [31:0] r;
    logic [31:0] hold_d = '0;
    bit          have_hold = 1'b0;
    logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    int cyc = 0;
    acc_clr = 1'b0;
    while ((cyc < 400 || q_d.size() != 0) && cyc < 1000) begin
      in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      alufn     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (have_hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== hold_d) begin n_err++; $display("FAIL rnd_hold c=%0d: got v=%b d=%h expected v=1 d=%h", cyc, out_valid, out_data, hold_d); end
      end
      n_cmp++; if (in_ready !== !(out_valid && !out_ready)) begin n_err++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", cyc, in_ready, !(out_valid && !out_ready)); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q_d.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious c=%0d: got d=%h expected no result", cyc, out_data);
        end else begin
          if (out_data !== q_d[0] || acc_out !== q_a[0]) begin
            n_err++; $display("FAIL rnd_data c=%0d: got d=%h acc=%h expected d=%h acc=%h", cyc, out_data, acc_out, q_d[0], q_a[0]);
          end
          void'(q_d.pop_front());
          void'(q_a.pop_front());
        end
      end
      have_hold = out_valid && !out_ready;
      hold_d    = out_data;
      if (in_valid && in_ready) begin
        r = ref_prod(a, b, alufn[0]);
        if (alufn[1]) begin
          r = macc + r;
          macc = r;
        end
        q_d.push_back(r);
        q_a.push_back(macc);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (q_d.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d results outstanding expected 0", q_d.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alufn = 2'b00;
    acc_clr = 1'b0; out_ready = 1'b1;
    test_reset();
    test_latency();
    test_signed();
    test_mac();
    test_wrap_collision();
    test_backpressure();
    test_reset_midstream();
    // Accumulator is zero after the mid-stream reset; the random model starts there.
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
